// File: rtl/control_sequencer_if.sv
// Control bus of the 8-bit bus computer: opcode/flag inputs to the sequencer
// and every load/drive/step strobe it issues to the datapath registers.
// Timing contract (no valid/ready handshake here): the sequencer changes state
// on posedge clk and all strobes are level signals that settle before the
// negedge, where the datapath registers sample them; opcode and flags must be
// stable from the negedge until the following posedge.
interface control_sequencer_if;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;
  logic       pc_oe;
  logic       pc_ie;
  logic       pc_step;
  logic       mar_ie;
  logic       ram_oe;
  logic       ram_ie;
  logic       ir_ie;
  logic       ir_oe;
  logic       a_ie;
  logic       a_oe;
  logic       b_ie;
  logic       alu_oe;
  logic       alu_sub;
  logic       flags_ie;
  logic       out_ie;
  logic [2:0] tstate;
  logic       instr_done;
  logic       halted;

  // Sequencer side
  modport master (
    input  opcode, flag_c, flag_z,
    output pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie,
           tstate, instr_done, halted
  );

  // Datapath side
  modport slave (
    output opcode, flag_c, flag_z,
    input  pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie,
           tstate, instr_done, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit bus computer. A T-state counter steps on
// posedge clk; the strobes are a combinational decode of the T-state, opcode,
// flags and halt state. T0/T1 fetch, T2.. execute, instr_done marks the last
// T-state of each instruction. The run/halt state and the T-state are visible
// on the bus as halted and tstate.
module control_sequencer #(
  parameter int T_MAX           = 5,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  control_sequencer_if.master  bus
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } mode_e;

  localparam logic [2:0] T_LAST = 3'(T_MAX - 1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  mode_e      mode_q, mode_d;
  logic [2:0] t_q, t_d;

  logic pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe;
  logic a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie;
  logic done, halt_req;

  // State register: T-state counter and run/halt mode
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q    <= 3'd0;
      mode_q <= S_RUN;
    end else begin
      t_q    <= t_d;
      mode_q <= mode_d;
    end
  end

  // Microcode decode: strobes from {tstate, opcode, flags, halt}; all zero in reset or halt
  always_comb begin
    pc_oe    = 1'b0;
    pc_ie    = 1'b0;
    pc_step  = 1'b0;
    mar_ie   = 1'b0;
    ram_oe   = 1'b0;
    ram_ie   = 1'b0;
    ir_ie    = 1'b0;
    ir_oe    = 1'b0;
    a_ie     = 1'b0;
    a_oe     = 1'b0;
    b_ie     = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    flags_ie = 1'b0;
    out_ie   = 1'b0;
    done     = 1'b0;
    halt_req = 1'b0;
    if (!rst && mode_q == S_RUN && t_q <= T_LAST) begin
      case (t_q)
        3'd0: begin
          pc_oe  = 1'b1;
          mar_ie = 1'b1;
        end
        3'd1: begin
          ram_oe  = 1'b1;
          ir_ie   = 1'b1;
          pc_step = 1'b1;
        end
        default: begin
          case (bus.opcode)
            OP_LDA: begin
              if (t_q == 3'd2) begin
                ir_oe  = 1'b1;
                mar_ie = 1'b1;
              end else if (t_q == 3'd3) begin
                ram_oe = 1'b1;
                a_ie   = 1'b1;
                done   = 1'b1;
              end
            end
            OP_ADD, OP_SUB: begin
              if (t_q == 3'd2) begin
                ir_oe  = 1'b1;
                mar_ie = 1'b1;
              end else if (t_q == 3'd3) begin
                ram_oe  = 1'b1;
                b_ie    = 1'b1;
                alu_sub = (bus.opcode == OP_SUB);
              end else if (t_q == 3'd4) begin
                alu_oe   = 1'b1;
                a_ie     = 1'b1;
                flags_ie = 1'b1;
                alu_sub  = (bus.opcode == OP_SUB);
                done     = 1'b1;
              end
            end
            OP_STA: begin
              if (t_q == 3'd2) begin
                ir_oe  = 1'b1;
                mar_ie = 1'b1;
              end else if (t_q == 3'd3) begin
                a_oe   = 1'b1;
                ram_ie = 1'b1;
                done   = 1'b1;
              end
            end
            OP_LDI: begin
              if (t_q == 3'd2) begin
                ir_oe = 1'b1;
                a_ie  = 1'b1;
                done  = 1'b1;
              end
            end
            OP_JMP: begin
              if (t_q == 3'd2) begin
                ir_oe = 1'b1;
                pc_ie = 1'b1;
                done  = 1'b1;
              end
            end
            OP_JC, OP_JZ: begin
              // Taken jumps load the operand into PC; untaken ones are a bare T2
              if (t_q == 3'd2) begin
                done = 1'b1;
                if ((bus.opcode == OP_JC && bus.flag_c) ||
                    (bus.opcode == OP_JZ && bus.flag_z)) begin
                  ir_oe = 1'b1;
                  pc_ie = 1'b1;
                end
              end
            end
            OP_OUT: begin
              if (t_q == 3'd2) begin
                a_oe   = 1'b1;
                out_ie = 1'b1;
                done   = 1'b1;
              end
            end
            OP_NOP: begin
              if (t_q == 3'd2) done = 1'b1;
            end
            OP_HLT: begin
              if (t_q == 3'd2) begin
                done     = 1'b1;
                halt_req = 1'b1;
              end
            end
            default: begin
              // Undefined opcodes: NOP, or HLT when configured to trap them
              if (t_q == 3'd2) begin
                done     = 1'b1;
                halt_req = HALT_ON_ILLEGAL;
              end
            end
          endcase
        end
      endcase
    end
  end

  // Next state: wrap after the final T-state or any out-of-range value; halt pins T0
  always_comb begin
    t_d    = t_q + 3'd1;
    mode_d = mode_q;
    if (mode_q == S_HALT || done || t_q >= T_LAST) t_d = 3'd0;
    if (halt_req) mode_d = S_HALT;
  end

  assign bus.pc_oe      = pc_oe;
  assign bus.pc_ie      = pc_ie;
  assign bus.pc_step    = pc_step;
  assign bus.mar_ie     = mar_ie;
  assign bus.ram_oe     = ram_oe;
  assign bus.ram_ie     = ram_ie;
  assign bus.ir_ie      = ir_ie;
  assign bus.ir_oe      = ir_oe;
  assign bus.a_ie       = a_ie;
  assign bus.a_oe       = a_oe;
  assign bus.b_ie       = b_ie;
  assign bus.alu_oe     = alu_oe;
  assign bus.alu_sub    = alu_sub;
  assign bus.flags_ie   = flags_ie;
  assign bus.out_ie     = out_ie;
  assign bus.instr_done = done;
  assign bus.tstate     = t_q;
  assign bus.halted     = (mode_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed reset/instruction/halt scenarios, a
// second instance that traps illegal opcodes, and a random instruction stream
// compared against per-instruction expected strobe sequences.
module tb_control_sequencer;

  // Strobe word layout, MSB to LSB
  localparam logic [15:0] PC_OE    = 16'h8000;
  localparam logic [15:0] PC_IE    = 16'h4000;
  localparam logic [15:0] PC_STEP  = 16'h2000;
  localparam logic [15:0] MAR_IE   = 16'h1000;
  localparam logic [15:0] RAM_OE   = 16'h0800;
  localparam logic [15:0] RAM_IE   = 16'h0400;
  localparam logic [15:0] IR_IE    = 16'h0200;
  localparam logic [15:0] IR_OE    = 16'h0100;
  localparam logic [15:0] A_IE     = 16'h0080;
  localparam logic [15:0] A_OE     = 16'h0040;
  localparam logic [15:0] B_IE     = 16'h0020;
  localparam logic [15:0] ALU_OE   = 16'h0010;
  localparam logic [15:0] ALU_SUB  = 16'h0008;
  localparam logic [15:0] FLAGS_IE = 16'h0004;
  localparam logic [15:0] OUT_IE   = 16'h0002;
  localparam logic [15:0] DONE     = 16'h0001;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  logic rst1;
  always #5 clk = ~clk;

  control_sequencer_if bus0 ();
  control_sequencer_if bus1 ();

  control_sequencer #(.T_MAX(5), .HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  control_sequencer #(.T_MAX(5), .HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  logic [15:0] obs0, obs1;
  assign obs0 = {bus0.pc_oe, bus0.pc_ie, bus0.pc_step, bus0.mar_ie, bus0.ram_oe,
                 bus0.ram_ie, bus0.ir_ie, bus0.ir_oe, bus0.a_ie, bus0.a_oe,
                 bus0.b_ie, bus0.alu_oe, bus0.alu_sub, bus0.flags_ie,
                 bus0.out_ie, bus0.instr_done};
  assign obs1 = {bus1.pc_oe, bus1.pc_ie, bus1.pc_step, bus1.mar_ie, bus1.ram_oe,
                 bus1.ram_ie, bus1.ir_ie, bus1.ir_oe, bus1.a_ie, bus1.a_oe,
                 bus1.b_ie, bus1.alu_oe, bus1.alu_sub, bus1.flags_ie,
                 bus1.out_ie, bus1.instr_done};

  // Scoreboard
  logic [15:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference microprogram: the strobe word expected in each T-state of one instruction
  function automatic void build_seq(input logic [3:0] op, input logic c, input logic z);
    logic [15:0] s;
    exp_q.delete();
    exp_q.push_back(PC_OE | MAR_IE);
    exp_q.push_back(RAM_OE | IR_IE | PC_STEP);
    case (op)
      4'h1: begin
        exp_q.push_back(IR_OE | MAR_IE);
        exp_q.push_back(RAM_OE | A_IE | DONE);
      end
      4'h2, 4'h3: begin
        s = (op == 4'h3) ? ALU_SUB : 16'h0000;
        exp_q.push_back(IR_OE | MAR_IE);
        exp_q.push_back(RAM_OE | B_IE | s);
        exp_q.push_back(ALU_OE | A_IE | FLAGS_IE | s | DONE);
      end
      4'h4: begin
        exp_q.push_back(IR_OE | MAR_IE);
        exp_q.push_back(A_OE | RAM_IE | DONE);
      end
      4'h5: exp_q.push_back(IR_OE | A_IE | DONE);
      4'h6: exp_q.push_back(IR_OE | PC_IE | DONE);
      4'h7: exp_q.push_back(c ? (IR_OE | PC_IE | DONE) : DONE);
      4'h8: exp_q.push_back(z ? (IR_OE | PC_IE | DONE) : DONE);
      4'hE: exp_q.push_back(A_OE | OUT_IE | DONE);
      default: exp_q.push_back(DONE);
    endcase
  endfunction

  // Driver: called just after a negedge with the DUT in T0; returns just after the
  // last checked T-state. max_cycles > 0 truncates the instruction.
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input int max_cycles);
    logic [15:0] w;
    int n;
    logic [15:0] drivers;
    build_seq(op, c, z);
    n = exp_q.size();
    if (max_cycles > 0 && max_cycles < n) n = max_cycles;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bus0.opcode = (i >= 2) ? op : 4'($urandom_range(0, 15));
      bus0.flag_c = c;
      bus0.flag_z = z;
      #1;
      w = exp_q.pop_front();
      check($sformatf("op%h_t%0d_strobes", op, i), obs0, w);
      check($sformatf("op%h_t%0d_tstate", op, i), 16'(bus0.tstate), 16'(i));
      check("halted_run", 16'(bus0.halted), 16'h0000);
      drivers = 16'($countones({bus0.pc_oe, bus0.ram_oe, bus0.ir_oe, bus0.a_oe, bus0.alu_oe}));
      check("bus_one_hot", 16'(drivers <= 16'd1), 16'h0001);
      check("pc_ie_step_excl", 16'(bus0.pc_ie & bus0.pc_step), 16'h0000);
      check("ram_ie_oe_excl", 16'(bus0.ram_ie & bus0.ram_oe), 16'h0000);
    end
    exp_q.delete();
  endtask

  logic [3:0] dir_ops[10] = '{4'h4, 4'h5, 4'h6, 4'hE, 4'h0, 4'h9, 4'h7, 4'h8, 4'h6, 4'h1};
  logic [3:0] rop;
  logic       rc, rz;

  initial begin
    rst         = 1'b1;
    rst1        = 1'b1;
    bus0.opcode = 4'h0;
    bus0.flag_c = 1'b0;
    bus0.flag_z = 1'b0;
    bus1.opcode = 4'h9;
    bus1.flag_c = 1'b0;
    bus1.flag_z = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_strobes", obs0, 16'h0000);
    check("reset_tstate", 16'(bus0.tstate), 16'h0000);
    check("reset_halted", 16'(bus0.halted), 16'h0000);
    rst = 1'b0;

    // Reset mid-T3 of ADD
    run_instr(4'h2, 1'b0, 1'b0, 4);
    rst = 1'b1;
    #1;
    check("rst_forces_strobes", obs0, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("rst_hold_strobes", obs0, 16'h0000);
      check("rst_hold_tstate", 16'(bus0.tstate), 16'h0000);
      check("rst_hold_halted", 16'(bus0.halted), 16'h0000);
    end
    rst = 1'b0;
    #1;
    check("after_rst_fetch", obs0, PC_OE | MAR_IE);
    check("after_rst_tstate", 16'(bus0.tstate), 16'h0000);

    // LDA, ADD, SUB back to back
    run_instr(4'h1, 1'b0, 1'b0, 0);
    @(negedge clk);
    run_instr(4'h2, 1'b1, 1'b0, 0);
    @(negedge clk);
    run_instr(4'h3, 1'b0, 1'b1, 0);
    @(negedge clk);

    // JC not taken, JZ taken
    run_instr(4'h7, 1'b0, 1'b1, 0);
    @(negedge clk);
    run_instr(4'h8, 1'b0, 1'b1, 0);
    @(negedge clk);

    // Remaining opcodes including illegal 9 as a 3-cycle NOP, and the other jump polarities
    foreach (dir_ops[k]) begin
      run_instr(dir_ops[k], 1'b1, 1'b0, 0);
      @(negedge clk);
    end

    // Halt
    run_instr(4'hF, 1'b0, 1'b0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus0.opcode = 4'($urandom_range(0, 15));
      #1;
      check("halt_strobes", obs0, 16'h0000);
      check("halt_tstate", 16'(bus0.tstate), 16'h0000);
      check("halt_sticky", 16'(bus0.halted), 16'h0001);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_clears_halt", 16'(bus0.halted), 16'h0000);
    rst = 1'b0;

    // Random instruction stream
    for (int k = 0; k < 1000; k++) begin
      rop = 4'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      rz  = 1'($urandom_range(0, 1));
      run_instr(rop, rc, rz, 0);
      @(negedge clk);
      if (rop == 4'hF) begin
        #1;
        check("rand_halted", 16'(bus0.halted), 16'h0001);
        check("rand_halt_strobes", obs0, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    // Illegal opcode trapping instance
    rst1 = 1'b0;
    #1;
    check("ill_t0", obs1, PC_OE | MAR_IE);
    @(negedge clk);
    #1;
    check("ill_t1", obs1, RAM_OE | IR_IE | PC_STEP);
    @(negedge clk);
    #1;
    check("ill_t2", obs1, DONE);
    check("ill_t2_tstate", 16'(bus1.tstate), 16'h0002);
    check("ill_t2_halted", 16'(bus1.halted), 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("ill_halted", 16'(bus1.halted), 16'h0001);
      check("ill_halt_strobes", obs1, 16'h0000);
      check("ill_halt_tstate", 16'(bus1.tstate), 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
